// File: rtl/seg_display_reader.sv
// seg_display_reader
// Snoops a time-multiplexed 4-digit common-anode seven-segment bus and
// rebuilds the displayed BCD value. Each digit slot is captured once its
// synchronized anode/segment sample has held steady for STABLE_CYCLES
// cycles. A small FSM collects digits 0..3 in order and commits a frame.
//
// Build option: define SEG_READER_HEX_EN to also decode the hex glyphs
// A,b,C,d,E,F as valid nibbles A..F.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   seg[6:0]    segment lines a..g (bit0=a), active-high
//   an_n[3:0]   anode enables, active-low, bit i = digit i
//   digits      last committed frame, digit i in [4i+3:4i]
//   digit_err   per-digit invalid-pattern flags for `digits`
//   frame_valid one-cycle pulse when digits/digit_err update
//   seq_err     one-cycle pulse when a frame is dropped for bad order
module seg_display_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        seq_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    WAIT_D0 = 2'd0,
    GOT_D0  = 2'd1,
    GOT_D1  = 2'd2,
    GOT_D2  = 2'd3
  } state_t;

  // Segment pattern (gfedcba) to {err, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
`ifdef SEG_READER_HEX_EN
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
`endif
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  logic [3:0]       an_s1, an_s2, an_p;
  logic [6:0]       seg_s1, seg_s2, seg_p;
  logic [CNT_W-1:0] cnt;
  logic             fired;
  logic             same_c;
  logic             fire_c;
  logic [1:0]       idx_c;
  logic [4:0]       dec_c;

  logic             cap_vld;
  logic [1:0]       cap_idx;
  logic [3:0]       cap_nib;
  logic             cap_err;

  state_t           state, state_n;
  logic [11:0]      sh_nib, sh_nib_n;
  logic [2:0]       sh_err, sh_err_n;
  logic [15:0]      digits_n;
  logic [3:0]       digit_err_n;
  logic             frame_valid_n, seq_err_n;

  // Two-flop synchronizer plus previous-sample register for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1  <= 4'hF;
      an_s2  <= 4'hF;
      an_p   <= 4'hF;
      seg_s1 <= 7'h00;
      seg_s2 <= 7'h00;
      seg_p  <= 7'h00;
    end else begin
      an_s1  <= an_n;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  assign same_c = ({an_s2, seg_s2} == {an_p, seg_p});
  // cnt describes the run of an_p/seg_p; fire exactly once per run, only
  // when a single anode is active.
  assign fire_c = (cnt == CNT_MAX) && !fired && $onehot(~an_p);
  assign dec_c  = decode(seg_p);

  always_comb begin
    idx_c = 2'd0;
    case (an_p)
      4'b1101: idx_c = 2'd1;
      4'b1011: idx_c = 2'd2;
      4'b0111: idx_c = 2'd3;
      default: idx_c = 2'd0;
    endcase
  end

  // Saturating stability counter and once-per-hold capture latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      fired <= 1'b0;
    end else begin
      if (!same_c) begin
        cnt   <= CNT_W'(1);
        fired <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_MAX) fired <= 1'b1;
      end
    end
  end

  // Registered capture event handed to the frame FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld <= 1'b0;
      cap_idx <= 2'd0;
      cap_nib <= 4'h0;
      cap_err <= 1'b0;
    end else begin
      cap_vld <= fire_c;
      if (fire_c) begin
        cap_idx <= idx_c;
        cap_nib <= dec_c[3:0];
        cap_err <= dec_c[4];
      end
    end
  end

  // Frame FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_D0;
      sh_nib      <= '0;
      sh_err      <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      state       <= state_n;
      sh_nib      <= sh_nib_n;
      sh_err      <= sh_err_n;
      digits      <= digits_n;
      digit_err   <= digit_err_n;
      frame_valid <= frame_valid_n;
      seq_err     <= seq_err_n;
    end
  end

  // Next-state logic. The encoding makes GOT_Dk expect digit index == state.
  always_comb begin
    state_n       = state;
    sh_nib_n      = sh_nib;
    sh_err_n      = sh_err;
    digits_n      = digits;
    digit_err_n   = digit_err;
    frame_valid_n = 1'b0;
    seq_err_n     = 1'b0;
    if (cap_vld) begin
      if (state == WAIT_D0) begin
        if (cap_idx == 2'd0) begin
          sh_nib_n[3:0] = cap_nib;
          sh_err_n[0]   = cap_err;
          state_n       = GOT_D0;
        end
      end else if (cap_idx == 2'(state)) begin
        case (cap_idx)
          2'd1: begin
            sh_nib_n[7:4] = cap_nib;
            sh_err_n[1]   = cap_err;
            state_n       = GOT_D1;
          end
          2'd2: begin
            sh_nib_n[11:8] = cap_nib;
            sh_err_n[2]    = cap_err;
            state_n        = GOT_D2;
          end
          default: begin
            digits_n      = {cap_nib, sh_nib};
            digit_err_n   = {cap_err, sh_err};
            frame_valid_n = 1'b1;
            state_n       = WAIT_D0;
          end
        endcase
      end else if (cap_idx == 2'd0) begin
        // Scan restarted early: keep the new digit 0 as the frame start.
        sh_nib_n[3:0] = cap_nib;
        sh_err_n[0]   = cap_err;
        state_n       = GOT_D0;
        seq_err_n     = 1'b1;
      end else begin
        sh_nib_n  = '0;
        sh_err_n  = '0;
        state_n   = WAIT_D0;
        seq_err_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_reader.sv
// Self-checking bench for seg_display_reader (STABLE_CYCLES=4).
// A monitor logs every frame_valid / seq_err pulse; each test pushes the
// events it expects and compares them in order against the log.
module tb_seg_display_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        seq_err;

  int total = 0;
  int bad   = 0;

  // Event word: {seq_err, frame_valid, digit_err, digits}
  logic [21:0] exp_q[$];
  logic [21:0] obs_mem[64];
  int          obs_wr = 0;
  int          obs_rd = 0;

  seg_display_reader #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an_n        (an_n),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid || seq_err) begin
      obs_mem[obs_wr % 64] <= {seq_err, frame_valid,
                               frame_valid ? digit_err : 4'h0,
                               frame_valid ? digits : 16'h0};
      obs_wr <= obs_wr + 1;
    end
  end

  task automatic show(input int idx, input logic [6:0] pat, input int dwell);
    an_n = ~(4'(1) << idx);
    seg  = pat;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic blank(input int n);
    an_n = 4'hF;
    seg  = 7'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg   = 7'h00;
    repeat (3) @(negedge clk);
    total++; if (digits !== 16'h0) begin bad++; $display("FAIL reset_digits: got %h want 0000", digits); end
    total++; if (digit_err !== 4'h0) begin bad++; $display("FAIL reset_err: got %b want 0000", digit_err); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq: got %b want 0", seq_err); end
    rst_n = 1'b1;
    blank(5);
  endtask

  task automatic test_basic_scan;
    logic [21:0] got, want;
    exp_q.push_back({2'b01, 4'h0, 16'h1279});
    show(0, 7'h6F, 8); show(1, 7'h07, 8); show(2, 7'h5B, 8); show(3, 7'h06, 8);
    blank(12);
    while (obs_rd < obs_wr) begin
      got = obs_mem[obs_rd % 64]; obs_rd++; total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL basic_event: got %h want none", got); end
      else begin want = exp_q.pop_front(); if (got !== want) begin bad++; $display("FAIL basic_event: got %h want %h", got, want); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_missing: got 0 want %0d more events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_hex_and_invalid;
    logic [21:0] got, want;
`ifdef SEG_READER_HEX_EN
    exp_q.push_back({2'b01, 4'b0000, 16'h1A79});
`else
    exp_q.push_back({2'b01, 4'b0100, 16'h1F79});
`endif
    show(0, 7'h6F, 8); show(1, 7'h07, 8); show(2, 7'h77, 8); show(3, 7'h06, 8);
    // all-dark pattern in digit 1 is always invalid
    exp_q.push_back({2'b01, 4'b0010, 16'h11F1});
    show(0, 7'h06, 8); show(1, 7'h00, 8); show(2, 7'h06, 8); show(3, 7'h06, 8);
    blank(12);
    while (obs_rd < obs_wr) begin
      got = obs_mem[obs_rd % 64]; obs_rd++; total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL hex_event: got %h want none", got); end
      else begin want = exp_q.pop_front(); if (got !== want) begin bad++; $display("FAIL hex_event: got %h want %h", got, want); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hex_missing: got 0 want %0d more events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_out_of_order;
    logic [21:0] got, want;
    exp_q.push_back({2'b10, 4'h0, 16'h0});
    show(0, 7'h6F, 8); show(1, 7'h07, 8); show(3, 7'h06, 8);
    blank(12);
    while (obs_rd < obs_wr) begin
      got = obs_mem[obs_rd % 64]; obs_rd++; total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL order_event: got %h want none", got); end
      else begin want = exp_q.pop_front(); if (got !== want) begin bad++; $display("FAIL order_event: got %h want %h", got, want); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL order_missing: got 0 want %0d more events", exp_q.size()); exp_q.delete(); end
    total++; if (digits !== 16'h11F1) begin bad++; $display("FAIL order_hold_digits: got %h want 11f1", digits); end
    total++; if (digit_err !== 4'b0010) begin bad++; $display("FAIL order_hold_err: got %b want 0010", digit_err); end
  endtask

  task automatic test_short_dwell_and_multi_anode;
    logic [21:0] got;
    show(0, 7'h3F, 3); show(1, 7'h06, 3); show(2, 7'h5B, 3); show(3, 7'h4F, 3);
    an_n = 4'b1100;
    seg  = 7'h3F;
    repeat (20) @(negedge clk);
    blank(12);
    while (obs_rd < obs_wr) begin
      got = obs_mem[obs_rd % 64]; obs_rd++; total++;
      bad++; $display("FAIL glitch_event: got %h want none", got);
    end
    total++; if (digits !== 16'h11F1) begin bad++; $display("FAIL glitch_digits: got %h want 11f1", digits); end
  endtask

  task automatic test_reset_mid_frame;
    logic [21:0] got, want;
    show(0, 7'h06, 10); show(1, 7'h5B, 10); show(2, 7'h4F, 10);
    rst_n = 1'b0;
    #1;
    total++; if (digits !== 16'h0) begin bad++; $display("FAIL midrst_digits: got %h want 0000", digits); end
    total++; if (digit_err !== 4'h0) begin bad++; $display("FAIL midrst_err: got %b want 0000", digit_err); end
    total++; if (frame_valid !== 1'b0 || seq_err !== 1'b0) begin bad++; $display("FAIL midrst_pulses: got %b%b want 00", frame_valid, seq_err); end
    @(negedge clk);
    an_n = 4'hF;
    seg  = 7'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    blank(10);
    exp_q.push_back({2'b01, 4'h0, 16'h0000});
    show(0, 7'h3F, 8); show(1, 7'h3F, 8); show(2, 7'h3F, 8); show(3, 7'h3F, 8);
    blank(12);
    while (obs_rd < obs_wr) begin
      got = obs_mem[obs_rd % 64]; obs_rd++; total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL midrst_event: got %h want none", got); end
      else begin want = exp_q.pop_front(); if (got !== want) begin bad++; $display("FAIL midrst_event: got %h want %h", got, want); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_missing: got 0 want %0d more events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_long_hold;
    logic [21:0] got, want;
    // A repeated digit-0 capture would raise seq_err; one capture lets the frame complete.
    exp_q.push_back({2'b01, 4'h0, 16'h0864});
    show(0, 7'h66, 100); show(1, 7'h7D, 8); show(2, 7'h7F, 8); show(3, 7'h3F, 8);
    blank(12);
    while (obs_rd < obs_wr) begin
      got = obs_mem[obs_rd % 64]; obs_rd++; total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL hold_event: got %h want none", got); end
      else begin want = exp_q.pop_front(); if (got !== want) begin bad++; $display("FAIL hold_event: got %h want %h", got, want); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hold_missing: got 0 want %0d more events", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back;
    logic [21:0] got, want;
    exp_q.push_back({2'b01, 4'h0, 16'h9753});
    exp_q.push_back({2'b01, 4'h0, 16'h3210});
    show(0, 7'h4F, 6); show(1, 7'h6D, 6); show(2, 7'h07, 6); show(3, 7'h6F, 6);
    show(0, 7'h3F, 6); show(1, 7'h06, 6); show(2, 7'h5B, 6); show(3, 7'h4F, 6);
    blank(12);
    while (obs_rd < obs_wr) begin
      got = obs_mem[obs_rd % 64]; obs_rd++; total++;
      if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_event: got %h want none", got); end
      else begin want = exp_q.pop_front(); if (got !== want) begin bad++; $display("FAIL b2b_event: got %h want %h", got, want); end end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing: got 0 want %0d more events", exp_q.size()); exp_q.delete(); end
    total++; if (digits !== 16'h3210) begin bad++; $display("FAIL b2b_final: got %h want 3210", digits); end
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg   = 7'h00;
    @(negedge clk);
    test_reset;
    test_basic_scan;
    test_hex_and_invalid;
    test_out_of_order;
    test_short_dwell_and_multi_anode;
    test_reset_mid_frame;
    test_long_hold;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_reader.md
# seg_display_reader

Snoops a time-multiplexed 4-digit common-anode seven-segment bus (active-high segments a..g, active-low anodes) and reconstructs the displayed BCD value. It is the receive-side counterpart of the segment decoder: it maps each captured segment pattern back to a digit and assembles a full frame once all four digits have been scanned in order. It sits between the display pins and the self-test/readback logic.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples (anode + segments) required to capture a digit; legal range 2..255.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment lines, bit0=a … bit6=g, active-high.
- an_n  input  4  anode enables, active-low; bit i selects digit i (digit 0 = least significant).
- digits  output  16  last complete frame, 4 BCD nibbles, digit i in bits [4i+3:4i].
- digit_err  output  4  per-digit invalid-pattern flag for the frame in `digits`.
- frame_valid  output  1  one-cycle pulse when `digits`/`digit_err` update.
- seq_err  output  1  one-cycle pulse when a frame is dropped for out-of-order capture.

## Operation
- Input stage: `seg` and `an_n` pass through a 2-flop synchronizer.
- Stability counter: increments while synced `{an_n,seg}` equals the previous synced sample, clears to 1 on change. Capture fires once when the count reaches STABLE_CYCLES and exactly one `an_n` bit is low; further cycles of the same hold do not re-capture.
- Blanking: no anode low, or more than one low, is never captured; counter still tracks but capture is suppressed.
- Pattern decode (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other pattern (including 00) → nibble F, error bit 1.
- Frame FSM, states WAIT_D0, GOT_D0, GOT_D1, GOT_D2:
  - WAIT_D0: capture of digit 0 → store, GOT_D0; capture of any other digit ignored, no seq_err.
  - GOT_Dk: capture of digit k+1 → store, next state; capture of digit 0 → restore digit 0, GOT_D0, seq_err pulse; capture of any other digit → discard shadow, WAIT_D0, seq_err pulse.
  - GOT_D2 + digit 3 capture → commit all four nibbles and error bits to outputs, frame_valid pulse, WAIT_D0.
- Shadow registers hold partial frames; outputs change only on commit.
- Reset (any time, including mid-frame): digits=0000, digit_err=0, frame_valid=0, seq_err=0, FSM WAIT_D0, counter 0, synchronizer an_n flops=4'hF, seg flops=0. Partial frame is lost.

## Timing
- Input change at pin → synced at cycle +2; capture decision registered at cycle +1+STABLE_CYCLES after the first synced sample of the new value.
- Commit: `digits`, `digit_err`, `frame_valid` update in the cycle after digit-3 capture registers; `seq_err` pulses in the cycle after the offending capture.
- frame_valid and seq_err never assert in the same cycle.
- Minimum anode dwell for reliable capture: STABLE_CYCLES+2 cycles.
- Counter saturates at STABLE_CYCLES; no wrap.

## Configuration
- SEG_READER_HEX_EN defined: patterns A=77, b=7C, C=39, d=5E, E=79, F=71 additionally decode to nibbles A..F with error bit 0.
- Undefined: those patterns are invalid (nibble F, error bit 1). Decimal decode unchanged in both builds.

## Test plan
- Scan digits 0..3 with patterns 6F,07,5B,06 (dwell 8 cycles each, STABLE_CYCLES=4) → one frame_valid, digits=16'h1279, digit_err=0.
- Digit 2 pattern 77 in an otherwise valid scan → without macro digits[11:8]=F, digit_err=4'b0100; with SEG_READER_HEX_EN digits[11:8]=A, digit_err=0.
- Scan order 0,1,3 → seq_err pulse after digit-3 capture, no frame_valid, outputs keep prior frame.
- Dwell of 3 synced cycles per digit (< STABLE_CYCLES) → no captures, no pulses; two anodes low simultaneously for 20 cycles → no capture.
- Assert rst_n low while in GOT_D2 → outputs zero immediately; next full scan 3F,3F,3F,3F → digits=0000, frame_valid once.
- Hold digit 0 stable for 100 cycles → exactly one capture (FSM GOT_D0), no repeated seq_err.
